// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters (issue, wait, respond).
// Define ARB_ROUND_ROBIN_EN to replace fixed priority plus starvation guard with round-robin ties.
module mem_port_arbiter #(
    parameter int WIDTH        = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [WIDTH-1:0]      if_rdata_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [WIDTH-1:0]      d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [WIDTH-1:0]      d_rdata_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]      mem_wdata_o,
    input  logic [WIDTH-1:0]      mem_rdata_i,
    output logic                  busy_o
);
    localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3;
    localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    logic [1:0]            state_q, state_d;
    logic [LW-1:0]         lat_q, lat_d;
    logic                  own_d_q, own_d_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
    logic                  pick_d;
    logic                  idle_req;

    assign idle_req = (state_q == S_IDLE) && (if_req_i || d_req_i);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q;
    // On a tie, whoever did not own the previous access wins.
    assign pick_d = d_req_i && (!if_req_i || !last_d_q);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            last_d_q <= 1'b0;
        else if (idle_req)
            last_d_q <= pick_d;
    end
`else
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_q, starve_d;
    logic          starved;

    assign starved = if_req_i && (starve_q == SW'(STARVE_LIMIT));
    assign pick_d  = d_req_i && !starved;

    // Counts data wins over a waiting fetch; any fetch win or idle fetch line clears it.
    always_comb begin
        starve_d = starve_q;
        if (state_q == S_IDLE)
            starve_d = !(if_req_i && pick_d) ? '0 :
                       (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            starve_q <= '0;
        else
            starve_q <= starve_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        own_d_d     = own_d_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (idle_req) begin
                    state_d     = S_ISSUE;
                    own_d_d     = pick_d;
                    mem_we_d    = pick_d && d_we_i;
                    mem_addr_d  = pick_d ? d_addr_i : if_addr_i;
                    mem_wdata_d = pick_d ? d_wdata_i : '0;
                end
            end
            S_ISSUE: begin
                lat_d   = LW'(MEM_LATENCY - 1);
                state_d = (MEM_LATENCY == 1) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                lat_d   = lat_q - LW'(1);
                state_d = (lat_q == LW'(1)) ? S_RESP : S_WAIT;
            end
            S_RESP: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            lat_q       <= '0;
            own_d_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            own_d_q     <= own_d_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy_o      = state_q != S_IDLE;
    assign mem_en_o    = state_q == S_ISSUE;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_gnt_o    = (state_q == S_ISSUE) && !own_d_q;
    assign d_gnt_o     = (state_q == S_ISSUE) && own_d_q;
    assign if_rvalid_o = (state_q == S_RESP) && !own_d_q;
    assign d_rvalid_o  = (state_q == S_RESP) && own_d_q;
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign d_rdata_o   = (d_rvalid_o && !mem_we_q) ? mem_rdata_i : '0;
endmodule

// File: doc/mem_port_arbiter.md
Name:
mem_port_arbiter

Overview:
- Shares the single-ported unified memory between two requesters: CPU instruction-fetch port (if_*) and data load/store port (d_*).
- Sits between the cpu datapath and the memory model.
- Sequences each access through issue, latency wait and response.
- Data has fixed priority, with a starvation guard so fetch always progresses.

Parameters:
- WIDTH, 32, data width of all data buses.
- ADDR_WIDTH, 32, address width.
- MEM_LATENCY, 2, cycles from the mem_en cycle to valid mem_rdata; legal range >= 1.
- STARVE_LIMIT, 4, consecutive data grants allowed while if_req is pending before fetch is forced.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_gnt  out  1  one-cycle pulse: fetch request accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  WIDTH  fetch read data.
- d_req  in  1  data request; held with d_we, d_addr, d_wdata stable until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  WIDTH  write data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse: read data valid, or write completion.
- d_rdata  out  WIDTH  load data; 0 for writes.
- mem_en  out  1  memory access strobe, high for exactly one cycle per access.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  WIDTH  memory write data.
- mem_rdata  in  WIDTH  memory read data, valid MEM_LATENCY cycles after mem_en.
- busy  out  1  1 when state != IDLE.

Behaviour:
- Reset:
  - All outputs 0, state IDLE, owner = none, starvation counter 0, latency counter 0.
  - Reset mid-transaction abandons the access: no gnt or rvalid is issued, and late mem_rdata is ignored.
- IDLE:
  - Samples requests. No request: stay in IDLE.
  - Winner is latched as owner; mem_addr, mem_we and mem_wdata are registered from the winner's inputs; next state is ISSUE.
- ISSUE (1 cycle):
  - mem_en = 1 and owner gnt = 1, both in this same cycle.
  - For a fetch owner, mem_we = 0 and mem_wdata = 0.
  - Latency counter loads MEM_LATENCY-1; next state is WAIT, or RESP if MEM_LATENCY = 1.
- WAIT:
  - mem_en = 0; counter decrements each cycle.
  - When counter = 1, next state is RESP.
- RESP (1 cycle):
  - Owner rvalid = 1; rdata = mem_rdata combinationally, forced to 0 when the owner performed a write.
  - Non-owner rdata stays 0. Next state is IDLE.
- Timing: request seen in IDLE at cycle N gives gnt/mem_en at N+1 and rvalid at N+1+MEM_LATENCY. Minimum spacing between accesses is MEM_LATENCY+2 cycles.
- Arbitration (default):
  - d_req beats if_req.
  - Starvation counter increments on every data grant made while if_req = 1.
  - It clears on a fetch grant, or on any IDLE cycle where if_req = 0.
  - When counter = STARVE_LIMIT and if_req = 1, fetch wins regardless of d_req.
  - Counter saturates at STARVE_LIMIT.
- Requests deasserted before grant are simply not considered; the protocol violation needs no error output.
- Requests arriving while busy wait; they are sampled only in IDLE.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - Starvation counter and STARVE_LIMIT are unused.
  - A 1-bit last-owner flag, reset to fetch, decides ties.
  - On simultaneous requests, the requester not granted last wins.
  - A single request always wins.
- Undefined: fixed-priority-with-starvation-guard behaviour as above.

Test Plan:
- Fetch read, MEM_LATENCY=2: if_req=1, if_addr=0x40 at cycle 0 -> cycle 1: if_gnt=1, mem_en=1, mem_addr=0x40, mem_we=0. Memory drives 0x1234_5678 -> cycle 3: if_rvalid=1, if_rdata=0x1234_5678. busy high cycles 1-3.
- Simultaneous: if_req and d_req (read, 0x200) both at cycle 0 -> d_gnt at cycle 1, d_rvalid at cycle 3. if_gnt at cycle 5 -> if_rvalid at cycle 7.
- Starvation, STARVE_LIMIT=4: d_req and if_req held continuously -> first 4 grants are d_gnt, 5th is if_gnt, 6th is d_gnt. With ARB_ROUND_ROBIN_EN defined, grants alternate d, if, d, if.
- Data write: d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF -> one cycle with mem_en=1, mem_we=1, mem_wdata=0xDEAD_BEEF. d_rvalid pulses with d_rdata=0; if_rvalid stays 0.
- Reset in WAIT: rst=1 one cycle after a fetch's ISSUE -> all outputs 0 next cycle, no if_rvalid ever. A d_req issued after reset gets d_gnt exactly 1 cycle after being sampled in IDLE.
- MEM_LATENCY=1: single d read -> d_gnt at cycle 1, d_rvalid at cycle 2, IDLE at cycle 3.
